// File: rtl/lift_req_queue.sv
// Hall-call request queue for a four-floor lift.
// Debounced-level buttons are edge detected, deduplicated against requests
// already captured or queued, and pushed one per cycle (lowest button index
// first) into a small FIFO that the lift controller drains with lift_done.
module lift_req_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn,
  input  logic       lift_done,
  output logic [2:0] req_code,
  output logic       q_empty,
  output logic       q_full,
  output logic [2:0] count,
  output logic [5:0] pending
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  // FIFO stores the button index (0..5); the external code is derived on read.
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [2:0]    count_q, count_d;
  logic [5:0]    btn_q;
  logic [5:0]    cap_q, cap_d;
  logic [5:0]    inq_q, inq_d;

  logic       empty, full;
  logic       pop, push;
  logic [2:0] head_idx;
  logic [2:0] push_idx;
  logic [5:0] press;
  logic [5:0] pop_mask;
  logic [5:0] push_mask;

  // Button index to lift request code.
  function automatic logic [2:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 3'b001;
      3'd1:    code_of = 3'b010;
      3'd2:    code_of = 3'b011;
      3'd3:    code_of = 3'b110;
      3'd4:    code_of = 3'b111;
      3'd5:    code_of = 3'b100;
      default: code_of = 3'b000;
    endcase
  endfunction

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    ptr_inc = (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count_q == 3'd0);
  assign full     = (count_q == 3'(DEPTH));
  assign head_idx = mem_q[rd_q];

  // Push/pop decisions, dedup and next-state for all control registers.
  always_comb begin
    press     = btn & ~btn_q;
    pop       = lift_done & ~empty;
    pop_mask  = pop ? (6'b000001 << head_idx) : 6'b000000;

    // Lowest-index captured request wins the single push slot. A pop in the
    // same cycle frees a slot, so a full queue can still accept it.
    push_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (cap_q[i]) push_idx = 3'(i);
    end
    push      = (|cap_q) && (!full || pop);
    push_mask = push ? (6'b000001 << push_idx) : 6'b000000;

    // A press is new unless the request is still queued (and not leaving
    // this cycle) or already captured.
    cap_d = (cap_q & ~push_mask) | (press & ~(inq_q & ~pop_mask) & ~cap_q);
    inq_d = (inq_q & ~pop_mask) | push_mask;

    rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d    = push ? ptr_inc(wr_q) : wr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  // Control state: pointers, count, edge-detect sample, capture and queued sets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= 3'd0;
      btn_q   <= 6'b000000;
      cap_q   <= 6'b000000;
      inq_q   <= 6'b000000;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      btn_q   <= btn;
      cap_q   <= cap_d;
      inq_q   <= inq_d;
    end
  end

  // FIFO storage; contents are only meaningful between rd and wr pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= push_idx;
  end

  assign req_code = empty ? 3'b000 : code_of(head_idx);
  assign q_empty  = empty;
  assign q_full   = full;
  assign count    = count_q;
  assign pending  = cap_q | inq_q;

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue with a scoreboard of expected head codes.
module tb_lift_req_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn;
  logic       lift_done;
  logic [2:0] req_code;
  logic       q_empty;
  logic       q_full;
  logic [2:0] count;
  logic [5:0] pending;

  int n_cmp = 0;
  int n_mis = 0;
  logic [2:0] sb[$];

  lift_req_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .lift_done(lift_done),
    .req_code(req_code), .q_empty(q_empty), .q_full(q_full),
    .count(count), .pending(pending)
  );

  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input int idx);
    case (idx)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b011;
      3: return 3'b110;
      4: return 3'b111;
      5: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Compare head against the scoreboard, then pop it with one lift_done pulse.
  task automatic pop_head(input string tag);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      exp = sb.pop_front();
      chk(tag, {5'd0, req_code}, {5'd0, exp});
    end
    lift_done = 1'b1;
    tick();
    lift_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn = 6'b0; lift_done = 1'b0;
    tick(); tick();
    chk("rst_code",    {5'd0, req_code}, 8'd0);
    chk("rst_empty",   {7'd0, q_empty},  8'd1);
    chk("rst_full",    {7'd0, q_full},   8'd0);
    chk("rst_count",   {5'd0, count},    8'd0);
    chk("rst_pending", {2'd0, pending},  8'd0);

    rst_n = 1'b1;
    tick();

    // Single press of 3U.
    btn = 6'b000100; tick();
    chk("single_pend", {2'd0, pending}, 8'h04);
    chk("single_cnt0", {5'd0, count},   8'd0);
    btn = 6'b000000; tick();
    sb.push_back(3'b011);
    chk("single_code",  {5'd0, req_code}, 8'h03);
    chk("single_empty", {7'd0, q_empty},  8'd0);
    chk("single_cnt1",  {5'd0, count},    8'd1);
    pop_head("single_pop");
    chk("single_drain", {7'd0, q_empty}, 8'd1);

    // Order: 4D then 1U, then pop both.
    btn = 6'b100000; tick();
    btn = 6'b100001; tick();
    btn = 6'b000000; tick();
    sb.push_back(3'b100); sb.push_back(3'b001);
    chk("order_cnt2", {5'd0, count}, 8'd2);
    pop_head("order_pop1");
    chk("order_cnt1", {5'd0, count}, 8'd1);
    pop_head("order_pop2");
    chk("order_cnt0",  {5'd0, count},   8'd0);
    chk("order_empty", {7'd0, q_empty}, 8'd1);
    lift_done = 1'b1; tick(); lift_done = 1'b0;
    chk("idle_done_cnt",  {5'd0, count},    8'd0);
    chk("idle_done_code", {5'd0, req_code}, 8'd0);

    // Dedup of 2U while queued, then pop+press in the same cycle.
    btn = 6'b000010; tick();
    btn = 6'b000000; tick();
    sb.push_back(3'b010);
    for (int k = 0; k < 2; k++) begin
      btn = 6'b000010; tick();
      btn = 6'b000000; tick();
    end
    chk("dedup_cnt",  {5'd0, count},   8'd1);
    chk("dedup_pend", {2'd0, pending}, 8'h02);
    chk("repress_head", {5'd0, req_code}, {5'd0, sb.pop_front()});
    btn = 6'b000010; lift_done = 1'b1; tick();
    btn = 6'b000000; lift_done = 1'b0;
    chk("repress_pend", {2'd0, pending}, 8'h02);
    tick();
    sb.push_back(3'b010);
    chk("repress_cnt", {5'd0, count}, 8'd1);
    pop_head("repress_pop");

    // Full: all six pressed at once.
    btn = 6'b111111; tick();
    btn = 6'b000000;
    for (int k = 0; k < 6; k++) tick();
    sb.push_back(3'b001); sb.push_back(3'b010);
    sb.push_back(3'b011); sb.push_back(3'b110);
    chk("full_flag", {7'd0, q_full},  8'd1);
    chk("full_cnt",  {5'd0, count},   8'd4);
    chk("full_pend", {2'd0, pending}, 8'h3f);
    pop_head("full_pop1");
    sb.push_back(3'b111);
    chk("full_refill_cnt",  {5'd0, count},   8'd4);
    chk("full_refill_pend", {2'd0, pending}, 8'h3e);
    pop_head("full_pop2");
    sb.push_back(3'b100);
    chk("full_refill2_cnt", {5'd0, count}, 8'd4);
    chk("full_refill2_pend", {2'd0, pending}, 8'h3c);
    for (int k = 0; k < 4; k++) pop_head("full_drain");
    chk("full_drained", {7'd0, q_empty}, 8'd1);

    // Wrap: ten press/pop rounds walk the pointers around several times.
    for (int r = 0; r < 10; r++) begin
      btn = 6'b000001 << (r % 6); tick();
      btn = 6'b000000;
      if (r % 2 == 1) begin
        btn = 6'b000001 << ((r + 1) % 6); tick();
        btn = 6'b000000; tick();
        sb.push_back(code_of(r % 6));
        sb.push_back(code_of((r + 1) % 6));
        chk("wrap_cnt2", {5'd0, count}, 8'd2);
        pop_head("wrap_pop_a");
        pop_head("wrap_pop_b");
      end else begin
        tick();
        sb.push_back(code_of(r % 6));
        chk("wrap_cnt1", {5'd0, count}, 8'd1);
        pop_head("wrap_pop");
      end
    end
    chk("wrap_empty", {7'd0, q_empty}, 8'd1);

    // Reset mid-operation with 1U held.
    btn = 6'b000111; tick();
    btn = 6'b000001; tick(); tick(); tick();
    chk("pre_rst_cnt", {5'd0, count}, 8'd3);
    rst_n = 1'b0; lift_done = 1'b1; tick();
    chk("mid_rst_code",  {5'd0, req_code}, 8'd0);
    chk("mid_rst_empty", {7'd0, q_empty},  8'd1);
    chk("mid_rst_full",  {7'd0, q_full},   8'd0);
    chk("mid_rst_cnt",   {5'd0, count},    8'd0);
    chk("mid_rst_pend",  {2'd0, pending},  8'd0);
    tick();
    sb.delete();
    rst_n = 1'b1; lift_done = 1'b0; btn = 6'b000000;
    tick(); tick();
    chk("post_rst_cnt",  {5'd0, count},   8'd0);
    chk("post_rst_pend", {2'd0, pending}, 8'd0);
    btn = 6'b000001; tick();
    chk("post_rst_cap", {2'd0, pending}, 8'h01);
    tick();
    sb.push_back(3'b001);
    chk("post_rst_cnt1", {5'd0, count}, 8'd1);
    tick(); tick();
    chk("post_rst_once", {5'd0, count}, 8'd1);
    pop_head("post_rst_pop");
    chk("post_rst_empty", {7'd0, q_empty}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
